// File: rtl/demultiplexer_tdm.sv
// TDM receive demultiplexer: rebuilds a WIDTH-bit frame from a swept 1-bit stream.
// Optional DEMUX_FRAME_CNT_EN adds an 8-bit delivered-frame counter output.
module demultiplexer_tdm #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             Y,
    input  logic [SEL_W-1:0] C,
    output logic [WIDTH-1:0] X,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             seq_err,
`ifdef DEMUX_FRAME_CNT_EN
    output logic             overrun,
    output logic [7:0]       frame_cnt
`else
    output logic             overrun
`endif
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             valid_q, valid_d;
    logic             seq_err_q, seq_err_d;
    logic             overrun_q, overrun_d;
    logic             complete;
    logic             deliver;

    assign deliver = valid_q && out_ready;

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        shadow_d  = shadow_q;
        x_d       = x_q;
        valid_d   = valid_q;
        seq_err_d = 1'b0;
        overrun_d = 1'b0;
        complete  = 1'b0;

        if (deliver) begin
            valid_d = 1'b0;
        end

        if (in_valid) begin
            case (state_q)
                IDLE: begin
                    if (C == '0) begin
                        shadow_d[0] = Y;
                        exp_d       = SEL_W'(1);
                        state_d     = COLLECT;
                    end
                end
                COLLECT: begin
                    if (C == exp_q) begin
                        shadow_d[C] = Y;
                        if (C == LAST) begin
                            complete = 1'b1;
                            exp_d    = '0;
                            state_d  = IDLE;
                        end else begin
                            exp_d = exp_q + SEL_W'(1);
                        end
                    end else if (C == '0) begin
                        // Out-of-order channel 0 is treated as the start of a fresh sweep.
                        seq_err_d   = 1'b1;
                        shadow_d[0] = Y;
                        exp_d       = SEL_W'(1);
                    end else begin
                        seq_err_d = 1'b1;
                        exp_d     = '0;
                        state_d   = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    exp_d   = '0;
                end
            endcase
        end

        // shadow_d already carries the final bit, so it is the whole new frame.
        if (complete) begin
            if (!valid_q || out_ready) begin
                x_d     = shadow_d;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            exp_q     <= '0;
            shadow_q  <= '0;
            x_q       <= '0;
            valid_q   <= 1'b0;
            seq_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            shadow_q  <= shadow_d;
            x_q       <= x_d;
            valid_q   <= valid_d;
            seq_err_q <= seq_err_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef DEMUX_FRAME_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (deliver) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign frame_cnt = cnt_q;
`endif

    assign X         = x_q;
    assign out_valid = valid_q;
    assign seq_err   = seq_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_demultiplexer_tdm.sv
// Directed bench for demultiplexer_tdm; frame counter checks run when DEMUX_FRAME_CNT_EN is defined.
module tb_demultiplexer_tdm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       Y;
    logic [1:0] C;
    logic [3:0] X;
    logic       out_valid;
    logic       out_ready;
    logic       seq_err;
    logic       overrun;
`ifdef DEMUX_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    demultiplexer_tdm #(.WIDTH(4), .SEL_W(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .Y         (Y),
        .C         (C),
        .X         (X),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .seq_err   (seq_err),
`ifdef DEMUX_FRAME_CNT_EN
        .overrun   (overrun),
        .frame_cnt (frame_cnt)
`else
        .overrun   (overrun)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
    task automatic smp(input logic [1:0] c, input logic y);
        in_valid = 1'b1;
        C        = c;
        Y        = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [3:0] v);
        for (int c = 0; c < 4; c++) begin
            smp(2'(c), v[c]);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        Y         = 1'b0;
        C         = 2'd0;
        out_ready = 1'b1;
        #1;
        chk("rst_X", 32'(X), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_seqerr", 32'(seq_err), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle();

        // Basic sweep Y=1,0,1,1
        smp(2'd0, 1'b1);
        smp(2'd1, 1'b0);
        smp(2'd2, 1'b1);
        chk("t2_valid_early", 32'(out_valid), 32'h0);
        smp(2'd3, 1'b1);
        chk("t2_X", 32'(X), 32'hD);
        chk("t2_valid", 32'(out_valid), 32'h1);
        idle();
        chk("t2_valid_clr", 32'(out_valid), 32'h0);

        // Exhaustive frames with 2-cycle idle gaps
        for (int s = 0; s < 16; s++) begin
            frame(4'(s));
            chk($sformatf("t3_X_%0d", s), 32'(X), 32'(s));
            chk($sformatf("t3_valid_%0d", s), 32'(out_valid), 32'h1);
            idle();
            chk($sformatf("t3_gap_err_%0d", s), 32'(seq_err), 32'h0);
            idle();
        end

        // Non-zero channel while idle is ignored silently
        smp(2'd2, 1'b1);
        chk("idle_ign_err", 32'(seq_err), 32'h0);
        chk("idle_ign_valid", 32'(out_valid), 32'h0);

        // Order errors
        smp(2'd0, 1'b1);
        smp(2'd1, 1'b1);
        smp(2'd3, 1'b1);
        chk("t4_err1", 32'(seq_err), 32'h1);
        chk("t4_noframe1", 32'(out_valid), 32'h0);
        idle();
        chk("t4_err1_pulse", 32'(seq_err), 32'h0);
        smp(2'd0, 1'b1);
        chk("t4_start_ok", 32'(seq_err), 32'h0);
        smp(2'd2, 1'b1);
        chk("t4_err2", 32'(seq_err), 32'h1);
        chk("t4_noframe2", 32'(out_valid), 32'h0);
        frame(4'b0110);
        chk("t4_X", 32'(X), 32'h6);
        chk("t4_valid", 32'(out_valid), 32'h1);
        chk("t4_clean_err", 32'(seq_err), 32'h0);
        idle();

        // Restart on out-of-order channel 0 keeps collecting
        smp(2'd0, 1'b0);
        smp(2'd1, 1'b0);
        smp(2'd0, 1'b1);
        chk("restart_err", 32'(seq_err), 32'h1);
        smp(2'd1, 1'b1);
        smp(2'd2, 1'b0);
        smp(2'd3, 1'b0);
        chk("restart_X", 32'(X), 32'h3);
        chk("restart_valid", 32'(out_valid), 32'h1);
        idle();

        // Back-to-back frames with ready held high
        frame(4'h9);
        chk("b2b_X1", 32'(X), 32'h9);
        smp(2'd0, 1'b0);
        chk("b2b_clr", 32'(out_valid), 32'h0);
        smp(2'd1, 1'b1);
        smp(2'd2, 1'b1);
        smp(2'd3, 1'b0);
        chk("b2b_X2", 32'(X), 32'h6);
        chk("b2b_valid2", 32'(out_valid), 32'h1);
        idle();

        // Backpressure: B dropped while A pending
        out_ready = 1'b0;
        frame(4'hA);
        chk("t5_XA", 32'(X), 32'hA);
        chk("t5_validA", 32'(out_valid), 32'h1);
        smp(2'd0, 1'b1);
        smp(2'd1, 1'b0);
        smp(2'd2, 1'b1);
        chk("t5_no_ov_early", 32'(overrun), 32'h0);
        smp(2'd3, 1'b0);
        chk("t5_overrun", 32'(overrun), 32'h1);
        chk("t5_X_hold", 32'(X), 32'hA);
        idle();
        chk("t5_overrun_pulse", 32'(overrun), 32'h0);
        chk("t5_valid_hold", 32'(out_valid), 32'h1);
        chk("t5_X_hold2", 32'(X), 32'hA);
        out_ready = 1'b1;
        idle();
        chk("t5_valid_clr", 32'(out_valid), 32'h0);

        // Completion on the same edge that pending output is accepted
        out_ready = 1'b0;
        frame(4'h3);
        smp(2'd0, 1'b0);
        smp(2'd1, 1'b0);
        smp(2'd2, 1'b1);
        out_ready = 1'b1;
        smp(2'd3, 1'b1);
        chk("reload_X", 32'(X), 32'hC);
        chk("reload_valid", 32'(out_valid), 32'h1);
        chk("reload_no_ov", 32'(overrun), 32'h0);
        idle();
        chk("reload_clr", 32'(out_valid), 32'h0);

        // Reset mid-stream with a pending frame and a partial frame
        out_ready = 1'b0;
        frame(4'h5);
        smp(2'd0, 1'b1);
        smp(2'd1, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t1_X", 32'(X), 32'h0);
        chk("t1_valid", 32'(out_valid), 32'h0);
        chk("t1_seqerr", 32'(seq_err), 32'h0);
        chk("t1_overrun", 32'(overrun), 32'h0);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        smp(2'd2, 1'b1);
        smp(2'd3, 1'b1);
        chk("t1_partial_lost", 32'(out_valid), 32'h0);
        chk("t1_partial_noerr", 32'(seq_err), 32'h0);
        frame(4'hE);
        chk("t1_after_X", 32'(X), 32'hE);
        idle();

`ifdef DEMUX_FRAME_CNT_EN
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("t6_rst", 32'(frame_cnt), 32'h0);
        for (int k = 0; k < 257; k++) begin
            frame(4'(k));
        end
        idle();
        chk("t6_wrap", 32'(frame_cnt), 32'h1);
        out_ready = 1'b0;
        frame(4'hA);
        frame(4'h5);
        chk("t6_drop_ov", 32'(overrun), 32'h1);
        out_ready = 1'b1;
        idle();
        idle();
        chk("t6_drop_cnt", 32'(frame_cnt), 32'h2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
